// File: rtl/fpnew_pkg.sv
// Shared types and constants for the FPNEW request path: the issue-buffer
// request struct, its field enums and the issue-buffer depth ceiling.
package fpnew_pkg;

    localparam int unsigned ISSUE_BUF_MAX_DEPTH = 16;
    localparam int unsigned FPNEW_WIDTH         = 32;
    localparam int unsigned FPNEW_TAG_W         = 8;

    typedef enum logic [2:0] {
        RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4, DYN = 3'd7
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD = 4'd0, FNMSUB = 4'd1, ADD = 4'd2, MUL = 4'd3, DIV = 4'd4,
        SQRT = 4'd5, SGNJ = 4'd6, MINMAX = 4'd7, CMP = 4'd8, CLASSIFY = 4'd9,
        F2F = 4'd10, F2I = 4'd11, I2F = 4'd12
    } operation_e;

    typedef enum logic [2:0] {
        FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8 = 2'd0, INT16 = 2'd1, INT32 = 2'd2, INT64 = 2'd3
    } int_format_e;

    // The tag field is a fixed-width carrier; narrower TagType values ride in its low bits.
    typedef struct packed {
        logic [2:0][FPNEW_WIDTH-1:0] operands;
        roundmode_e                  rnd_mode;
        operation_e                  op;
        logic                        op_mod;
        fp_format_e                  src_fmt;
        fp_format_e                  dst_fmt;
        int_format_e                 int_fmt;
        logic                        vectorial_op;
        logic [FPNEW_TAG_W-1:0]      tag;
    } fpnew_req_t;

endpackage

// File: rtl/fpnew_issue_buffer.sv
// Circular request FIFO in front of the FPU input handshake.
// Optional FPNEW_ISSUE_BUF_FALLTHROUGH_EN lets an empty buffer forward the request combinationally.
module fpnew_issue_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  fpnew_req_t                 in_req_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output fpnew_req_t                 out_req_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    if (Width != FPNEW_WIDTH || $bits(TagType) > FPNEW_TAG_W ||
        Depth < 2 || Depth > ISSUE_BUF_MAX_DEPTH) begin : g_cfg_check
        $error("fpnew_issue_buffer: unsupported Width, TagType or Depth");
    end

    fpnew_req_t        r_mem [Depth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;

    logic              w_in_ready;
    logic              w_out_valid;
    fpnew_req_t        w_out_req;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [PtrW-1:0]   w_wptr_inc;
    logic [PtrW-1:0]   w_rptr_inc;
    logic [CntW-1:0]   w_count_nxt;

    // Handshake decode; readiness depends only on occupancy and flush, never on out_ready_i.
    always_comb begin
        w_empty     = (r_count == '0);
        w_in_ready  = (r_count < CntW'(Depth)) && !flush_i;
`ifdef FPNEW_ISSUE_BUF_FALLTHROUGH_EN
        w_out_valid = (!w_empty || in_valid_i) && !flush_i;
        w_out_req   = w_empty ? in_req_i : r_mem[r_rptr];
`else
        w_out_valid = !w_empty && !flush_i;
        w_out_req   = r_mem[r_rptr];
`endif
        w_push      = in_valid_i && w_in_ready;
        w_pop       = w_out_valid && out_ready_i;
        w_wptr_inc  = (r_wptr == PtrW'(Depth-1)) ? '0 : r_wptr + PtrW'(1);
        w_rptr_inc  = (r_rptr == PtrW'(Depth-1)) ? '0 : r_rptr + PtrW'(1);
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CntW'(1);
            2'b01:   w_count_nxt = r_count - CntW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy state; a fall-through bypass advances both pointers together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_push ? w_wptr_inc : r_wptr;
            r_rptr  <= w_pop  ? w_rptr_inc : r_rptr;
            r_count <= w_count_nxt;
        end
    end

    // Entry storage carries no reset; only the pointers decide what is live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_req_i;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_req_o   = w_out_req;
    assign count_o     = r_count;
    assign busy_o      = !w_empty;

endmodule

// File: tb/tb_fpnew_issue_buffer.sv
// Bench for fpnew_issue_buffer: directed vector table, hand-written corner
// sequences and a randomized run checked against a queue model.
module tb_fpnew_issue_buffer;
    import fpnew_pkg::*;

    localparam int DEPTH = 4;
`ifdef FPNEW_ISSUE_BUF_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    fpnew_req_t in_req_i = '0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       flush_i = 1'b0;
    fpnew_req_t out_req_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [2:0] count_o;
    logic       busy_o;

    fpnew_issue_buffer #(.Width(32), .Depth(DEPTH), .TagType(logic [7:0])) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_req_i(in_req_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .out_req_o(out_req_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .count_o(count_o),
        .busy_o(busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    fpnew_req_t mq[$];

    typedef struct {
        bit         v, f, r;
        logic [7:0] tag;
        int         cnt;
        bit         rdy, ovld;
        logic [7:0] head;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic fpnew_req_t mk_req(input logic [7:0] tag);
        fpnew_req_t r;
        r.operands[0]  = $urandom;
        r.operands[1]  = $urandom;
        r.operands[2]  = $urandom;
        r.rnd_mode     = roundmode_e'(3'($urandom));
        r.op           = operation_e'(4'($urandom));
        r.op_mod       = 1'($urandom);
        r.src_fmt      = fp_format_e'(3'($urandom));
        r.dst_fmt      = fp_format_e'(3'($urandom));
        r.int_fmt      = int_format_e'(2'($urandom));
        r.vectorial_op = 1'($urandom);
        r.tag          = tag;
        return r;
    endfunction

    // Drive one cycle's inputs (called just after a rising edge) and move to the sampling point.
    task automatic apply(input bit v, input bit f, input bit r, input logic [7:0] tag);
        in_valid_i  = v;
        flush_i     = f;
        out_ready_i = r;
        in_req_i    = mk_req(tag);
        @(negedge clk_i);
    endtask

    // Compare all outputs against the queue model for the inputs currently applied.
    task automatic check_model(input string nm);
        int n;
        bit ev;
        n  = mq.size();
        ev = !flush_i && (n > 0 || (FT && in_valid_i));
        chk({nm, ".count"},    128'(count_o),     128'(n));
        chk({nm, ".busy"},     128'(busy_o),      128'(n != 0));
        chk({nm, ".in_ready"}, 128'(in_ready_o),  128'(n < DEPTH && !flush_i));
        chk({nm, ".valid"},    128'(out_valid_o), 128'(ev));
        if (ev) chk({nm, ".req"}, 128'(out_req_o), 128'(n > 0 ? mq[0] : in_req_i));
    endtask

    // Take the rising edge and apply the FIFO rules to the model queue.
    task automatic advance();
        int n;
        bit push, pop, ev;
        n    = mq.size();
        ev   = !flush_i && (n > 0 || (FT && in_valid_i));
        push = in_valid_i && n < DEPTH && !flush_i;
        pop  = ev && out_ready_i;
        @(posedge clk_i);
        if (flush_i) mq.delete();
        else begin
            if (push) mq.push_back(in_req_i);
            if (pop) void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            apply(1'b0, 1'b0, 1'b1, 8'd0);
            check_model("drain");
            advance();
        end
        chk("drain.empty", 128'(count_o), 128'(0));
    endtask

    initial begin
        //          v     f     r     tag    cnt rdy   ovld  head
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 0, 1'b1, FT,   8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1, 1'b1, 1'b1, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd2, 2, 1'b1, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd3, 3, 1'b1, 1'b1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd4, 4, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd4, 4, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd4, 3, 1'b1, 1'b1, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'd0, 4, 1'b0, 1'b1, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3, 1'b1, 1'b1, 8'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 2, 1'b1, 1'b1, 8'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd0, 1, 1'b1, 1'b1, 8'd4};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b1, 1'b0, 8'd0};

        // Reset state, checked while reset is still held.
        #2;
        chk("rst.count", 128'(count_o),     128'(0));
        chk("rst.busy",  128'(busy_o),      128'(0));
        chk("rst.valid", 128'(out_valid_o), 128'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst.in_ready", 128'(in_ready_o), 128'(1));
        @(posedge clk_i);
        #1;

        // Fill to full, stall the fifth request, pop while full, then drain in order.
        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].tag);
            chk($sformatf("tbl%0d.count", i),    128'(count_o),     128'(tbl[i].cnt));
            chk($sformatf("tbl%0d.busy", i),     128'(busy_o),      128'(tbl[i].cnt != 0));
            chk($sformatf("tbl%0d.in_ready", i), 128'(in_ready_o),  128'(tbl[i].rdy));
            chk($sformatf("tbl%0d.valid", i),    128'(out_valid_o), 128'(tbl[i].ovld));
            if (tbl[i].ovld) chk($sformatf("tbl%0d.tag", i), 128'(out_req_o.tag), 128'(tbl[i].head));
            check_model($sformatf("tbl%0d", i));
            advance();
        end

        // Steady push+pop at count 2 across pointer wrap.
        apply(1'b1, 1'b0, 1'b0, 8'd60); check_model("wrap.fill"); advance();
        apply(1'b1, 1'b0, 1'b0, 8'd61); check_model("wrap.fill"); advance();
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 1'b1, 8'(62 + i));
            chk($sformatf("wrap%0d.count", i), 128'(count_o),        128'(2));
            chk($sformatf("wrap%0d.tag", i),   128'(out_req_o.tag),  128'(60 + i));
            check_model($sformatf("wrap%0d", i));
            advance();
        end
        drain();

        // Flush at count 3; the request offered during the flush must not be kept.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(40 + i)); check_model("flush.fill"); advance();
        end
        apply(1'b1, 1'b1, 1'b1, 8'd99);
        chk("flush.in_ready", 128'(in_ready_o),  128'(0));
        chk("flush.valid",    128'(out_valid_o), 128'(0));
        advance();
        apply(1'b0, 1'b0, 1'b0, 8'd0);
        chk("flush.count", 128'(count_o),     128'(0));
        chk("flush.busy",  128'(busy_o),      128'(0));
        chk("flush.valid2", 128'(out_valid_o), 128'(0));
        advance();
        apply(1'b1, 1'b0, 1'b0, 8'd50); check_model("flush.push"); advance();
        apply(1'b0, 1'b0, 1'b0, 8'd0);
        chk("flush.after_count", 128'(count_o),       128'(1));
        chk("flush.after_tag",   128'(out_req_o.tag), 128'(50));
        advance();
        drain();

        // Asynchronous reset mid-stream at count 2.
        apply(1'b1, 1'b0, 1'b0, 8'd30); advance();
        apply(1'b1, 1'b0, 1'b0, 8'd31); advance();
        in_valid_i = 1'b1;
        #2;
        chk("arst.pre_count", 128'(count_o), 128'(2));
        rst_i = 1'b1;
        #1;
        chk("arst.count", 128'(count_o),     128'(0));
        chk("arst.busy",  128'(busy_o),      128'(0));
        chk("arst.valid", 128'(out_valid_o), 128'(0));
        mq.delete();
        @(posedge clk_i);
        #3;
        in_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("arst.in_ready", 128'(in_ready_o), 128'(1));
        chk("arst.count2",   128'(count_o),    128'(0));
        @(posedge clk_i);
        #1;

`ifdef FPNEW_ISSUE_BUF_FALLTHROUGH_EN
        // Empty-buffer bypass: same-cycle valid and tag, nothing stored.
        apply(1'b1, 1'b0, 1'b1, 8'd7);
        chk("ft.valid", 128'(out_valid_o),   128'(1));
        chk("ft.tag",   128'(out_req_o.tag), 128'(7));
        chk("ft.count", 128'(count_o),       128'(0));
        advance();
        apply(1'b0, 1'b0, 1'b0, 8'd0);
        chk("ft.count_after", 128'(count_o), 128'(0));
        advance();
`endif

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 3) != 0), $urandom_range(0, 40) == 0,
                  1'($urandom_range(0, 2) != 0), 8'($urandom));
            check_model("rand");
            advance();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
